// File: rtl/fft_stage_scheduler.sv
// Butterfly issue sequencer for the in-place radix-2 FFT: walks stages and pair ids,
// throttles on an in-flight credit limit and drains the pipeline before each bank swap.
module fft_stage_scheduler #(
  parameter int N            = 32,
  parameter int MAX_INFLIGHT = 8,
  parameter int STAGE_W      = $clog2($clog2(N)),
  parameter int PAIR_W       = $clog2(N/2)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_retire,
  output logic               o_issue_valid,
  output logic [STAGE_W-1:0] o_stage,
  output logic [PAIR_W-1:0]  o_pair_id,
  output logic               o_bank_select,
  output logic               o_busy,
  output logic               o_fft_done,
  output logic               o_retire_err
);

  localparam int LOG2N = $clog2(N);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG2N - 1);
  localparam logic [PAIR_W-1:0]  LAST_PAIR  = PAIR_W'(N/2 - 1);
  localparam logic [CNT_W-1:0]   MAX_CNT    = CNT_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_inflight;
  logic [STAGE_W-1:0] r_stage;
  logic [PAIR_W-1:0]  r_pair;
  logic               r_bank;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               w_issue;
  logic               w_drained;

  assign w_issue   = (r_state == S_ISSUE) && (r_inflight < MAX_CNT);
  // A retire still landing this cycle means the last write-back is not yet in RAM.
  assign w_drained = (r_inflight == '0) && !i_retire;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_ISSUE;
      S_ISSUE: if (w_issue && (r_pair == LAST_PAIR)) w_next = S_DRAIN;
      S_DRAIN: if (w_drained) w_next = (r_stage == LAST_STAGE) ? S_DONE : S_ISSUE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_inflight <= '0;
      r_stage    <= '0;
      r_pair     <= '0;
      r_bank     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);

      if (w_issue && !i_retire) begin
        r_inflight <= r_inflight + CNT_W'(1);
      end else if (!w_issue && i_retire) begin
        if (r_inflight == '0) r_err      <= 1'b1;
        else                  r_inflight <= r_inflight - CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_stage <= '0;
            r_pair  <= '0;
            r_bank  <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (w_issue) r_pair <= (r_pair == LAST_PAIR) ? '0 : r_pair + PAIR_W'(1);
        end
        S_DRAIN: begin
          if (w_drained && (r_stage != LAST_STAGE)) begin
            r_stage <= r_stage + STAGE_W'(1);
            r_bank  <= ~r_bank;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_issue_valid = w_issue;
  assign o_stage       = r_stage;
  assign o_pair_id     = r_pair;
  assign o_bank_select = r_bank;
  assign o_busy        = r_busy;
  assign o_fft_done    = r_done;
  assign o_retire_err  = r_err;

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Scoreboard bench for fft_stage_scheduler: dutA (8 credits) runs directed frames,
// dutB (2 credits) runs the credit-throttle frame alongside.
module tb_fft_stage_scheduler;

  localparam int N      = 32;
  localparam int STAGES = 5;
  localparam int PAIRS  = 16;
  localparam int LAT    = 4;
  localparam int HOLD   = 10;
  localparam int BUDGET = 1000;

  typedef struct {
    int st;
    int pr;
    int bk;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN, startA, startB, manualRetireA, echoA, retireA, retireB;
  logic ivA, bankA, busyA, doneA, errA;
  logic ivB, bankB, busyB, doneB, errB;
  logic [2:0] stageA, stageB;
  logic [3:0] pairA, pairB;

  assign retireA = echoA | manualRetireA;

  fft_stage_scheduler #(.N(N), .MAX_INFLIGHT(8)) dutA (
    .i_clk(clk), .i_reset(rstN), .i_start(startA), .i_retire(retireA),
    .o_issue_valid(ivA), .o_stage(stageA), .o_pair_id(pairA), .o_bank_select(bankA),
    .o_busy(busyA), .o_fft_done(doneA), .o_retire_err(errA)
  );

  fft_stage_scheduler #(.N(N), .MAX_INFLIGHT(2)) dutB (
    .i_clk(clk), .i_reset(rstN), .i_start(startB), .i_retire(retireB),
    .o_issue_valid(ivB), .o_stage(stageB), .o_pair_id(pairB), .o_bank_select(bankB),
    .o_busy(busyB), .o_fft_done(doneB), .o_retire_err(errB)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  exp_t expQ[$];
  int doneQ[$];
  bit schedA[int];
  bit schedB[int];
  int issueCnt = 0;
  int doneCntA = 0;
  int doneCntB = 0;
  int lastIssueCyc = 0;
  int heldRetireCyc = -1;
  int holdSeen = 0;
  bit holdEnable = 0;
  int seqB = 0;
  int modelB = 0;
  int peakB = 0;
  int stallB = 0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input bit doStartA, input bit doStartB, input bit doReset,
                               input bit doRetire);
    @(posedge clk);
    #1;
    startA        = doStartA;
    startB        = doStartB;
    rstN          = !doReset;
    manualRetireA = doRetire;
  endtask

  task automatic pushFrame();
    exp_t e;
    for (int s = 0; s < STAGES; s++) begin
      for (int p = 0; p < PAIRS; p++) begin
        e.st = s;
        e.pr = p;
        e.bk = s & 1;
        expQ.push_back(e);
      end
    end
    doneQ.push_back(1);
    issueCnt = 0;
  endtask

  task automatic waitDoneA(input int target);
    int n = 0;
    while (doneCntA < target && n < BUDGET) begin
      applyStimulus(0, 0, 0, 0);
      n++;
    end
    if (doneCntA < target) begin
      total++;
      bad++;
      $display("[TB] FAIL doneA_timeout: got %0d done pulses expected %0d", doneCntA, target);
    end
  endtask

  task automatic checkResetValues(input string tag);
    @(negedge clk);
    checkOutput({tag, "_issue_valid"}, int'(ivA), 0);
    checkOutput({tag, "_busy"}, int'(busyA), 0);
    checkOutput({tag, "_fft_done"}, int'(doneA), 0);
    checkOutput({tag, "_stage"}, int'(stageA), 0);
    checkOutput({tag, "_pair_id"}, int'(pairA), 0);
    checkOutput({tag, "_bank_select"}, int'(bankA), 0);
    checkOutput({tag, "_retire_err"}, int'(errA), 0);
  endtask

  // dutA: retire echo plus scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    int l;
    if (!rstN) begin
      schedA.delete();
      echoA = 1'b0;
    end else begin
      if (ivA) begin
        l = LAT;
        if (holdEnable && stageA == 3'd0 && pairA == 4'(PAIRS - 1)) begin
          l = LAT + HOLD;
          heldRetireCyc = cyc + l;
        end
        schedA[cyc + l] = 1'b1;
      end
      echoA = schedA.exists(cyc);
      if (echoA) schedA.delete(cyc);

      if (holdEnable && cyc == heldRetireCyc) begin
        checkOutput("drain_hold_stage", int'(stageA), 0);
        checkOutput("drain_hold_issue_valid", int'(ivA), 0);
      end

      if (ivA) begin
        issueCnt++;
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_issue: got stage %0d pair %0d expected none", stageA, pairA);
        end else begin
          e = expQ.pop_front();
          checkOutput("issue_stage", int'(stageA), e.st);
          checkOutput("issue_pair_id", int'(pairA), e.pr);
          checkOutput("issue_bank_select", int'(bankA), e.bk);
          if (pairA != 4'd0) checkOutput("issue_gap", cyc - lastIssueCyc, 1);
          if (holdEnable && stageA == 3'd1 && pairA == 4'd0) begin
            checkOutput("drain_gate_release", cyc - heldRetireCyc, 2);
            holdSeen++;
          end
        end
        lastIssueCyc = cyc;
      end

      if (doneA) begin
        doneCntA++;
        if (doneQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_done: got pulse expected none");
        end else begin
          void'(doneQ.pop_front());
          checkOutput("done_remaining_issues", expQ.size(), 0);
          checkOutput("done_busy", int'(busyA), 1);
          checkOutput("done_issue_count", issueCnt, STAGES * PAIRS);
        end
      end
    end
  end

  // dutB: retire echo plus in-order issue check against a credit model
  always @(negedge clk) begin
    if (!rstN) begin
      schedB.delete();
      retireB = 1'b0;
      modelB = 0;
    end else begin
      retireB = schedB.exists(cyc);
      if (retireB) schedB.delete(cyc);
      if (modelB == 2) begin
        checkOutput("b_stall_at_limit", int'(ivB), 0);
        stallB++;
      end
      if (ivB) begin
        schedB[cyc + LAT] = 1'b1;
        checkOutput("b_issue_stage", int'(stageB), seqB / PAIRS);
        checkOutput("b_issue_pair_id", int'(pairB), seqB % PAIRS);
        checkOutput("b_issue_bank", int'(bankB), (seqB / PAIRS) & 1);
        seqB++;
      end
      modelB = modelB + int'(ivB) - int'(retireB);
      if (modelB > peakB) peakB = modelB;
      if (doneB) begin
        doneCntB++;
        checkOutput("b_issue_count", seqB, STAGES * PAIRS);
        checkOutput("b_peak_inflight", peakB, 2);
      end
    end
  end

  initial begin
    int n;
    rstN = 1'b0;
    startA = 1'b1;
    startB = 1'b1;
    manualRetireA = 1'b0;

    $display("[TB] reset with start held high");
    repeat (3) applyStimulus(1, 1, 1, 0);
    checkResetValues("reset");
    checkOutput("reset_b_issue_valid", int'(ivB), 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] full frame on dutA, credit-throttled frame on dutB");
    pushFrame();
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    waitDoneA(1);
    n = 0;
    while (doneCntB < 1 && n < BUDGET) begin
      applyStimulus(0, 0, 0, 0);
      n++;
    end
    checkOutput("b_done_count", doneCntB, 1);
    checkOutput("b_stalls_seen", int'(stallB > 0), 1);
    repeat (5) applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("post_frame_busy", int'(busyA), 0);
    checkOutput("post_frame_done_count", doneCntA, 1);

    $display("[TB] drain gate with held final retire of stage 0");
    holdEnable = 1;
    pushFrame();
    applyStimulus(1, 0, 0, 0);
    waitDoneA(2);
    holdEnable = 0;
    checkOutput("drain_gate_seen", holdSeen, 1);
    repeat (3) applyStimulus(0, 0, 0, 0);

    $display("[TB] spurious retire in idle");
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("retire_err_set", int'(errA), 1);
    checkOutput("retire_err_idle_busy", int'(busyA), 0);
    pushFrame();
    applyStimulus(1, 0, 0, 0);
    waitDoneA(3);
    @(negedge clk);
    checkOutput("retire_err_sticky", int'(errA), 1);
    repeat (3) applyStimulus(0, 0, 0, 0);

    $display("[TB] reset during stage 2");
    pushFrame();
    applyStimulus(1, 0, 0, 0);
    n = 0;
    while (stageA != 3'd2 && n < BUDGET) begin
      applyStimulus(0, 0, 0, 0);
      n++;
    end
    checkOutput("reached_stage2", int'(stageA), 2);
    applyStimulus(0, 0, 1, 0);
    expQ.delete();
    doneQ.delete();
    applyStimulus(0, 0, 0, 0);
    checkResetValues("midreset");
    applyStimulus(0, 0, 0, 0);
    pushFrame();
    applyStimulus(1, 0, 0, 0);
    waitDoneA(4);
    @(negedge clk);
    checkOutput("final_retire_err", int'(errA), 0);
    checkOutput("final_done_count", doneCntA, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
